// File: rtl/mprj_io_cfg_loader_if.sv
// Bundle between the system-control registers and the I/O loader engine.
// The register file (master side) answers cfg_rd_idx with cfg_rd_data combinationally.
interface mprj_io_cfg_loader_if #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int DIV_W    = 8
);
    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                start;
    logic [DIV_W-1:0]    clkdiv;
    logic [IDX_W-1:0]    cfg_rd_idx;
    logic [CFG_BITS-1:0] cfg_rd_data;
    logic                busy;
    logic                done;
    logic                mprj_io_loader_resetn;
    logic                mprj_io_loader_clock;
    logic                mprj_io_loader_data;

    modport master (
        output start, clkdiv, cfg_rd_data,
        input  cfg_rd_idx, busy, done,
        input  mprj_io_loader_resetn, mprj_io_loader_clock, mprj_io_loader_data
    );

    modport slave (
        input  start, clkdiv, cfg_rd_data,
        output cfg_rd_idx, busy, done,
        output mprj_io_loader_resetn, mprj_io_loader_clock, mprj_io_loader_data
    );
endinterface

// File: rtl/mprj_io_cfg_loader.sv
// Serial loader for the user-project pad configuration chain: clear, then shift each
// pad word MSB-first, last pad first. Optional abort input: MPRJ_IO_LOADER_ABORT_EN.
module mprj_io_cfg_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int DIV_W    = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef MPRJ_IO_LOADER_ABORT_EN
    input  logic abort,
`endif
    mprj_io_cfg_loader_if.slave bus
);
    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CFG_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_SHIFT, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [DIV_W-1:0]    tick_reg, tick_next;
    logic                phase_reg, phase_next;
    logic [IDX_W-1:0]    word_reg, word_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [CFG_BITS-1:0] shift_reg, shift_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                resetn_reg, resetn_next;
    logic                lclk_reg, lclk_next;
    logic                ldata_reg, ldata_next;

    // Half-period timer: phase 0 is the low half, phase 1 the high half of a bit period.
    logic                half_end, period_end;
    logic [DIV_W-1:0]    tick_adv;
    logic                phase_adv;

    assign half_end   = (tick_reg == div_reg);
    assign period_end = half_end && phase_reg;
    assign tick_adv   = half_end ? '0 : tick_reg + DIV_W'(1);
    assign phase_adv  = half_end ? ~phase_reg : phase_reg;

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        tick_next  = tick_reg;
        phase_next = phase_reg;
        word_next  = word_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_CLEAR;
                    div_next   = bus.clkdiv;
                    word_next  = LAST_WORD;
                    tick_next  = '0;
                    phase_next = 1'b0;
                end
            end
            S_CLEAR: begin
                tick_next  = tick_adv;
                phase_next = phase_adv;
                if (period_end) state_next = S_FETCH;
            end
            S_FETCH: begin
                shift_next = bus.cfg_rd_data;
                bit_next   = LAST_BIT;
                tick_next  = '0;
                phase_next = 1'b0;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                tick_next  = tick_adv;
                phase_next = phase_adv;
                if (period_end) begin
                    shift_next = shift_reg << 1;
                    if (bit_reg == '0) begin
                        if (word_reg == '0) begin
                            state_next = S_DONE;
                        end else begin
                            word_next  = word_reg - IDX_W'(1);
                            state_next = S_FETCH;
                        end
                    end else begin
                        bit_next = bit_reg - BIT_W'(1);
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
`ifdef MPRJ_IO_LOADER_ABORT_EN
        if (abort && (state_reg inside {S_CLEAR, S_FETCH, S_SHIFT})) state_next = S_IDLE;
`endif
        // Outputs are decoded from the next state so every port comes straight from a flop.
        busy_next   = state_next inside {S_CLEAR, S_FETCH, S_SHIFT};
        done_next   = (state_next == S_DONE);
        resetn_next = (state_next != S_CLEAR);
        lclk_next   = (state_next == S_SHIFT) && phase_next;
        ldata_next  = (state_next == S_SHIFT) && shift_next[CFG_BITS-1];
        idx_next    = (state_next == S_FETCH) ? word_next : idx_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            div_reg    <= '0;
            tick_reg   <= '0;
            phase_reg  <= 1'b0;
            word_reg   <= '0;
            idx_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            resetn_reg <= 1'b1;
            lclk_reg   <= 1'b0;
            ldata_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            tick_reg   <= tick_next;
            phase_reg  <= phase_next;
            word_reg   <= word_next;
            idx_reg    <= idx_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            resetn_reg <= resetn_next;
            lclk_reg   <= lclk_next;
            ldata_reg  <= ldata_next;
        end
    end

    assign bus.cfg_rd_idx            = idx_reg;
    assign bus.busy                  = busy_reg;
    assign bus.done                  = done_reg;
    assign bus.mprj_io_loader_resetn = resetn_reg;
    assign bus.mprj_io_loader_clock  = lclk_reg;
    assign bus.mprj_io_loader_data   = ldata_reg;
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Randomized bench for mprj_io_cfg_loader: expected stream and timing come from the
// closed-form load schedule and a register-file array.
module tb_mprj_io_cfg_loader;
    localparam int N  = 38;
    localparam int C  = 13;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef MPRJ_IO_LOADER_ABORT_EN
    logic abort = 1'b0;
`endif
    logic [C-1:0] regfile [N];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mprj_io_cfg_loader_if #(.NUM_PADS(N), .CFG_BITS(C), .DIV_W(DW)) bus ();

    mprj_io_cfg_loader #(.NUM_PADS(N), .CFG_BITS(C), .DIV_W(DW)) dut (
        .clk   (clk),
        .reset (rst),
`ifdef MPRJ_IO_LOADER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always_comb begin
        bus.cfg_rd_data = '0;
        if (int'(bus.cfg_rd_idx) < N) bus.cfg_rd_data = regfile[bus.cfg_rd_idx];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit idx_zero);
        check({tag, " busy"},   32'(bus.busy), 0);
        check({tag, " done"},   32'(bus.done), 0);
        check({tag, " resetn"}, 32'(bus.mprj_io_loader_resetn), 1);
        check({tag, " lclk"},   32'(bus.mprj_io_loader_clock), 0);
        check({tag, " ldata"},  32'(bus.mprj_io_loader_data), 0);
        if (idx_zero) check({tag, " idx"}, 32'(bus.cfg_rd_idx), 0);
    endtask

    // mode: 0 plain, 1 start while busy, 2 clkdiv change, 3 reset in 5th bit,
    //       4 abort in 3rd word, 5 abort together with start
    task automatic run_load(input int d, input int mode, input bit fixed, input string tag);
        int k, limit, expect_done, rises, done_cnt, done_k, rst_low, hi_len, exp_k;
        int pad, b, stream_err, idx_err, timing_err, last_chg_k;
        logic prev_clk, prev_data;
        bit stop;
        for (int p = 0; p < N; p++) regfile[p] = C'($urandom);
        if (fixed) begin
            regfile[1] = 13'h1A5B;
            regfile[0] = 13'h0403;
        end
        expect_done = 1 + 2 * (d + 1) * (1 + N * C) + N;
        limit = expect_done + 6;
        rises = 0; done_cnt = 0; done_k = -1; rst_low = 0; hi_len = 0; last_chg_k = 0;
        stream_err = 0; idx_err = 0; timing_err = 0; stop = 1'b0;
        prev_clk = 1'b0; prev_data = 1'b0;
        bus.clkdiv = DW'(d);
        bus.start  = 1'b1;
`ifdef MPRJ_IO_LOADER_ABORT_EN
        if (mode == 5) abort = 1'b1;
`endif
        @(negedge clk);
        bus.start = 1'b0;
`ifdef MPRJ_IO_LOADER_ABORT_EN
        abort = 1'b0;
`endif
        k = 1;
        while (!stop && k <= limit) begin
            if (k == 1) begin
                check({tag, " busy_rise"}, 32'(bus.busy), 1);
                check({tag, " resetn_fall"}, 32'(bus.mprj_io_loader_resetn), 0);
            end
            if (!bus.mprj_io_loader_resetn) rst_low++;
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bus.mprj_io_loader_data !== prev_data) begin
                if (bus.mprj_io_loader_clock) timing_err++;
                last_chg_k = k;
            end
            if (bus.mprj_io_loader_clock && !prev_clk) begin
                pad = N - 1 - rises / C;
                b   = C - 1 - rises % C;
                exp_k = 2 * (d + 1) + 2 + (d + 1) + (rises / C) * (1 + 2 * (d + 1) * C)
                        + (rises % C) * 2 * (d + 1);
                if (pad >= 0) begin
                    if (bus.mprj_io_loader_data !== regfile[pad][b]) stream_err++;
                    if (int'(bus.cfg_rd_idx) != pad) idx_err++;
                end else begin
                    stream_err++;
                end
                if (k != exp_k) timing_err++;
                if (k - last_chg_k < d + 1) timing_err++;
                rises++;
                hi_len = 0;
            end
            if (bus.mprj_io_loader_clock) hi_len++;
            if (!bus.mprj_io_loader_clock && prev_clk && hi_len != d + 1) timing_err++;
            prev_clk  = bus.mprj_io_loader_clock;
            prev_data = bus.mprj_io_loader_data;

            bus.start = (mode == 1 && (k == 100 || k == expect_done));
            if (mode == 2 && k == 200) bus.clkdiv = DW'(d ^ 5);
            if (mode == 3 && rises == 4 && !bus.mprj_io_loader_clock) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle({tag, " after_reset"}, 1'b1);
                stop = 1'b1;
            end
`ifdef MPRJ_IO_LOADER_ABORT_EN
            if (mode == 4 && rises == 2 * C + 3 && bus.mprj_io_loader_clock) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_idle({tag, " after_abort"}, 1'b0);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bus.done || bus.busy) done_cnt++;
                end
                stop = 1'b1;
            end
`endif
            if (!stop) begin
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        check({tag, " stream"}, 32'(stream_err), 0);
        check({tag, " rd_idx"}, 32'(idx_err), 0);
        check({tag, " timing"}, 32'(timing_err), 0);
        if (mode == 3 || mode == 4) begin
            check({tag, " no_done"}, 32'(done_cnt), 0);
        end else begin
            check({tag, " resetn_len"}, 32'(rst_low), 32'(2 * (d + 1)));
            check({tag, " done_cnt"}, 32'(done_cnt), 1);
            check({tag, " done_time"}, 32'(done_k), 32'(expect_done));
            check({tag, " bits"}, 32'(rises), 32'(N * C));
            check({tag, " idle_end"}, 32'(bus.busy), 0);
        end
        $display("load %s: d=%0d mode=%0d rises=%0d done_at=%0d", tag, d, mode, rises, done_k);
    endtask

    initial begin
        bus.start  = 1'b1;
        bus.clkdiv = '0;
        for (int p = 0; p < N; p++) regfile[p] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check_idle("reset", 1'b1);
        @(negedge clk);
        check_idle("reset_hold", 1'b1);

        run_load(0, 0, 1'b1, "basic");
        run_load(3, 0, 1'b0, "div3");
        run_load(3, 2, 1'b0, "div_change");
        run_load(int'($urandom_range(0, 2)), 1, 1'b0, "start_busy");
        run_load(255, 3, 1'b0, "reset_bit5");
        run_load(int'($urandom_range(0, 3)), 0, 1'b0, "after_reset");
`ifdef MPRJ_IO_LOADER_ABORT_EN
        run_load(1, 4, 1'b0, "abort");
        run_load(1, 5, 1'b0, "abort_start");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
